mdio_arbiter: RTL
=================

# mdio_arbiter

Shares the single PHY management bus (`phy_mdc` / `phy_mdio`) between two requesters, one per RGMII port. Each requester is typically a per-port link monitor or configuration engine. The block performs round-robin arbitration, then serializes one IEEE 802.3 Clause 22 read or write frame per grant and returns read data or an error. It sits in the core clock domain between the per-port management logic and the top-level MDIO tri-state pad (`phy_mdio = phy_mdio_tri ? phy_mdio_out : z`).

## Interface
- `CLK_DIV`, default 25. Core-clock cycles per MDC half-period (125 MHz / 50 = 2.5 MHz). Legal values are 2 and above.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `req[1:0]` in 2: per-requester transaction request; held high until the matching `ack`.
- `we_0`, `we_1` in 1: 1 = write, 0 = read.
- `phy_addr_0`, `phy_addr_1` in 5: PHY address.
- `reg_addr_0`, `reg_addr_1` in 5: register address.
- `wdata_0`, `wdata_1` in 16: write data.
- `ack[1:0]` out 2: one-cycle completion pulse for the granted requester.
- `rdata` out 16: read data. Valid while `ack` is high; holds its value until the next read completes.
- `err` out 1: valid with `ack`. Set to 1 if the PHY did not drive the second turnaround bit low on a read.
- `busy` out 1: a transaction is in progress.
- `phy_mdc` out 1: management clock, free-running.
- `phy_mdio_out` out 1: serial data to the pad.
- `phy_mdio_tri` out 1: 1 = drive the pad.
- `phy_mdio_in` in 1: serial data from the pad.

## Operation
- Divider: counter `div` runs 0..CLK_DIV-1. When `div==CLK_DIV-1`, `phy_mdc` toggles and `div` returns to 0.
  - `fall_tick` = toggle with `phy_mdc==1`.
  - `rise_tick` = toggle with `phy_mdc==0`.
- Arbitration in IDLE happens on any cycle with a nonzero `req`.
  - If exactly one request is present, it wins.
  - If both are present, the requester not granted last time wins. `last_grant` resets to 1, so requester 0 wins the first tie.
  - The grant latches `we`, `phy_addr`, `reg_addr` and `wdata` into a 64-bit frame register and sets `busy`.
- Frame, MSB first:
  - 32 × '1' preamble.
  - ST = 01.
  - OP = 01 for write, 10 for read.
  - PHYAD[4:0], REGAD[4:0].
  - TA: write drives 10; read drives nothing.
  - DATA[15:0]: write drives `wdata`; read receives.
- FSM states: IDLE, PRE (32 bits), HDR (14 bits), TA (2 bits), DATA (16 bits), DONE.
  - A 6-bit bit counter advances on each `fall_tick`. A new bit is presented on every `fall_tick`.
  - IDLE→PRE: first `fall_tick` after the grant.
  - PRE→HDR after bit 31.
  - HDR→TA after bit 45.
  - TA→DATA after bit 47.
  - DATA→DONE after bit 63.
  - DONE→IDLE on the next `fall_tick`. In that same cycle, `ack[g]` pulses and `busy` falls.
- `phy_mdio_tri` is 1 through PRE and HDR. For a write it stays 1 through TA and DATA. For a read it is 0 from the start of TA through DONE. It is 0 in IDLE.
- Read capture: on the `rise_tick` inside TA bit 47, `err` is set to the sampled `phy_mdio_in` value. On each `rise_tick` in DATA, the shift register takes `{rdata_sh[14:0], phy_mdio_in}`.
- A write always completes with `err=0`.
- The winning `req` bit is ignored after the grant. A requester that drops `req` before `ack` still receives its `ack`.
- Reset mid-frame clears everything immediately: no `ack`, tri-state released, MDC low.

## Timing
- Reset values:
  - `phy_mdc=0`, `phy_mdio_out=1`, `phy_mdio_tri=0`.
  - `ack=0`, `err=0`, `busy=0`, `rdata=0`.
  - `div=0`, state IDLE.
- Grant to `busy` is 1 cycle; `busy` is registered.
- First preamble bit appears at the next `fall_tick`, at most 2·CLK_DIV cycles after the grant.
- Frame length is 64 MDC periods, plus 1 period in DONE, so 65·2·CLK_DIV cycles from the first bit to `ack`.
- Back-to-back: a pending `req` is granted in the cycle after `ack`. The next frame starts one MDC period later, giving at least 1 idle MDC period between frames.
- All outputs are registered. `phy_mdio_out` changes only in the cycle where MDC falls, giving ≥ CLK_DIV cycles of setup and hold around the MDC rise.

## Test plan
- Single write, CLK_DIV=2, with `req=01`, `phy_addr_0=5'h04`, `reg_addr_0=5'h00`, `wdata_0=16'h1140`:
  - The bench decodes 32 ones, then `01 01 00100 00000 10 0001000101000000`.
  - `ack=01` pulses once with `err=0`.
  - `phy_mdio_tri` stays 1 for all 64 bits.
- Single read: `req=10`, `phy_addr_1=5'h05`, `reg_addr_1=5'h01`, and the PHY model drives TA bit 0 followed by `16'h796D`.
  - `ack=10` pulses once with `rdata=16'h796D` and `err=0`.
  - `phy_mdio_tri` is 0 from bit 46 onward.
- No PHY: read with `phy_mdio_in` pulled high → `ack` with `err=1`, `rdata=16'hFFFF`.
- Contention: `req=11` held from reset → grants alternate 0,1,0,1 across 4 frames, with ≥1 idle MDC period between frames and `busy` low for 1 cycle at each `ack`.
- Reset mid-frame: assert `reset=0` at bit 40 of a write → outputs take their reset values asynchronously and no `ack` occurs. After release, the held `req` restarts from preamble bit 0.
- MDC period: with CLK_DIV=25, measure `phy_mdc` period = 50 `clk` cycles and 50% duty, free-running while IDLE.

Source files
------------

// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one Clause 22 MDIO bus between two
// requesters. Each grant serializes one 64-bit read or write frame on
// phy_mdc/phy_mdio, then returns an ack, read data and a no-PHY error flag.
module mdio_arbiter #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic        we_0,
    input  logic        we_1,
    input  logic [4:0]  phy_addr_0,
    input  logic [4:0]  phy_addr_1,
    input  logic [4:0]  reg_addr_0,
    input  logic [4:0]  reg_addr_1,
    input  logic [15:0] wdata_0,
    input  logic [15:0] wdata_1,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        phy_mdc,
    output logic        phy_mdio_out,
    output logic        phy_mdio_tri,
    input  logic        phy_mdio_in
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } state_t;

    logic [DIV_W-1:0] div_reg;
    logic             mdc_reg;
    logic             tick;
    logic             fall_tick;
    logic             rise_tick;

    state_t      state_reg, state_next;
    logic        grant_reg, grant_next;
    logic        last_reg, last_next;
    logic        busy_reg, busy_next;
    logic        we_reg, we_next;
    logic [63:0] frame_reg, frame_next;
    logic [5:0]  bit_reg, bit_next;
    logic        out_reg, out_next;
    logic        tri_reg, tri_next;
    logic [1:0]  ack_reg, ack_next;
    logic        err_sh_reg, err_sh_next;
    logic [15:0] rsh_reg, rsh_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic        win;
    logic [1:0]  we_vec;
    logic [4:0]  phy_vec [2];
    logic [4:0]  reg_vec [2];
    logic [15:0] wd_vec  [2];
    logic [63:0] frame_cand [2];

    // Free-running MDC divider; MDC toggles every CLK_DIV core cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
            mdc_reg <= 1'b0;
        end else if (tick) begin
            div_reg <= '0;
            mdc_reg <= ~mdc_reg;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick      = (div_reg == DIV_LAST);
    assign fall_tick = tick & mdc_reg;
    assign rise_tick = tick & ~mdc_reg;

    assign we_vec     = {we_1, we_0};
    assign phy_vec[0] = phy_addr_0;
    assign phy_vec[1] = phy_addr_1;
    assign reg_vec[0] = reg_addr_0;
    assign reg_vec[1] = reg_addr_1;
    assign wd_vec[0]  = wdata_0;
    assign wd_vec[1]  = wdata_1;

    // Full frame image per requester; read frames carry ones where the PHY drives.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_frame
            assign frame_cand[gi] = {32'hFFFF_FFFF, 2'b01,
                                     we_vec[gi] ? 2'b01 : 2'b10,
                                     phy_vec[gi], reg_vec[gi],
                                     we_vec[gi] ? 2'b10 : 2'b11,
                                     we_vec[gi] ? wd_vec[gi] : 16'hFFFF};
        end
    endgenerate

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_reg;
        end
    end

    // Frame sequencer: next state, serial output, capture and completion.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        last_next   = last_reg;
        busy_next   = busy_reg;
        we_next     = we_reg;
        frame_next  = frame_reg;
        bit_next    = bit_reg;
        out_next    = out_reg;
        tri_next    = tri_reg;
        ack_next    = 2'b00;
        err_sh_next = err_sh_reg;
        rsh_next    = rsh_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!busy_reg) begin
                    if (req != 2'b00) begin
                        grant_next = win;
                        last_next  = win;
                        busy_next  = 1'b1;
                        we_next    = we_vec[win];
                        frame_next = frame_cand[win];
                    end
                end else if (fall_tick) begin
                    state_next = ST_PRE;
                    out_next   = frame_reg[63];
                    frame_next = {frame_reg[62:0], 1'b1};
                    tri_next   = 1'b1;
                    bit_next   = 6'd0;
                end
            end
            ST_PRE, ST_HDR, ST_TA, ST_DATA: begin
                if (fall_tick) begin
                    bit_next   = bit_reg + 6'd1;
                    out_next   = frame_reg[63];
                    frame_next = {frame_reg[62:0], 1'b1};
                    // Reads hand the line to the PHY from bit 46 onward.
                    tri_next   = we_reg || (bit_reg < 6'd45);
                    if (state_reg == ST_PRE && bit_reg == 6'd31) begin
                        state_next = ST_HDR;
                    end else if (state_reg == ST_HDR && bit_reg == 6'd45) begin
                        state_next = ST_TA;
                    end else if (state_reg == ST_TA && bit_reg == 6'd47) begin
                        state_next = ST_DATA;
                    end else if (state_reg == ST_DATA && bit_reg == 6'd63) begin
                        state_next = ST_DONE;
                        out_next   = 1'b1;
                        tri_next   = 1'b0;
                    end
                end
                if (rise_tick) begin
                    if (state_reg == ST_TA && bit_reg == 6'd47) begin
                        err_sh_next = phy_mdio_in;
                    end
                    if (state_reg == ST_DATA) begin
                        rsh_next = {rsh_reg[14:0], phy_mdio_in};
                    end
                end
            end
            ST_DONE: begin
                if (fall_tick) begin
                    state_next          = ST_IDLE;
                    busy_next           = 1'b0;
                    ack_next[grant_reg] = 1'b1;
                    if (we_reg) begin
                        err_next = 1'b0;
                    end else begin
                        err_next   = err_sh_reg;
                        rdata_next = rsh_reg;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state; reset drops everything mid-frame with no ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= 1'b0;
            last_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            we_reg     <= 1'b0;
            frame_reg  <= '0;
            bit_reg    <= '0;
            out_reg    <= 1'b1;
            tri_reg    <= 1'b0;
            ack_reg    <= 2'b00;
            err_sh_reg <= 1'b0;
            rsh_reg    <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            last_reg   <= last_next;
            busy_reg   <= busy_next;
            we_reg     <= we_next;
            frame_reg  <= frame_next;
            bit_reg    <= bit_next;
            out_reg    <= out_next;
            tri_reg    <= tri_next;
            ack_reg    <= ack_next;
            err_sh_reg <= err_sh_next;
            rsh_reg    <= rsh_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
        end
    end

    assign ack          = ack_reg;
    assign rdata        = rdata_reg;
    assign err          = err_reg;
    assign busy         = busy_reg;
    assign phy_mdc      = mdc_reg;
    assign phy_mdio_out = out_reg;
    assign phy_mdio_tri = tri_reg;

endmodule
